final_layer_scheduler: RTL

FINAL_LAYER_SCHEDULER -- requirements
Module: final_layer_scheduler

---
 rtl/final_layer_pkg.sv | 15 +
 rtl/xnor_popcount.sv | 25 ++
 rtl/final_layer_scheduler.sv | 123 ++++++++++++
 3 files changed

// File: rtl/final_layer_pkg.sv
// Shared constants and FSM state type for the binarized final-layer classifier.
package final_layer_pkg;

  localparam int unsigned NUM_INPUTS_DEFAULT  = 196;
  localparam int unsigned NUM_CLASSES_DEFAULT = 10;
  localparam int unsigned SCORE_W             = $clog2(NUM_INPUTS_DEFAULT + 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } fsm_state_e;

endpackage

// File: rtl/xnor_popcount.sv
// Combinational XNOR-match counter: number of bit positions where a_i equals b_i.
module xnor_popcount
  import final_layer_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = NUM_INPUTS_DEFAULT
) (
  input  logic [NUM_INPUTS-1:0]              a_i,
  input  logic [NUM_INPUTS-1:0]              b_i,
  output logic [$clog2(NUM_INPUTS + 1)-1:0]  count_o
);

  localparam int unsigned ScoreW = $clog2(NUM_INPUTS + 1);

  logic [NUM_INPUTS-1:0] match;

  assign match = ~(a_i ^ b_i);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      count_o = count_o + {{(ScoreW - 1){1'b0}}, match[i]};
    end
  end

endmodule

// File: rtl/final_layer_scheduler.sv
// Streams weight rows through one shared XNOR-popcount and reports the arg-max class.
// Optional max_score output is enabled by defining FINAL_LAYER_SCORE_OUT_EN.
module final_layer_scheduler
  import final_layer_pkg::*;
#(
  parameter int unsigned NUM_INPUTS  = NUM_INPUTS_DEFAULT,
  parameter int unsigned NUM_CLASSES = NUM_CLASSES_DEFAULT
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                start,
  input  logic [NUM_INPUTS-1:0]               data_in,
  output logic                                weight_rd_en,
  output logic [3:0]                          weight_addr,
  input  logic [NUM_INPUTS-1:0]               weight_data,
  output logic                                busy,
  output logic                                done,
  output logic [3:0]                          answer
`ifdef FINAL_LAYER_SCORE_OUT_EN
  ,
  output logic [$clog2(NUM_INPUTS + 1)-1:0]   max_score
`endif
);

  localparam int unsigned ScoreW  = $clog2(NUM_INPUTS + 1);
  localparam logic [3:0]  LastRow = 4'(NUM_CLASSES - 1);

  fsm_state_e            state_q, state_d;
  logic [NUM_INPUTS-1:0] data_q, data_d;
  logic [3:0]            addr_q, addr_d;
  logic [3:0]            row_q, row_d;
  logic [3:0]            index_q, index_d;
  logic [3:0]            answer_q, answer_d;
  logic [ScoreW-1:0]     max_q, max_d;
  logic                  valid_q, valid_d;
  logic [ScoreW-1:0]     score;
  logic                  accept, rd_en, take;

  xnor_popcount #(
    .NUM_INPUTS (NUM_INPUTS)
  ) u_popcount (
    .a_i     (weight_data),
    .b_i     (data_q),
    .count_o (score)
  );

  assign accept = start && ((state_q == StIdle) || (state_q == StDone));
  assign rd_en  = (state_q == StFetch);
  // Row 0 loads unconditionally; later rows need a strictly higher score, so ties keep the lowest.
  assign take   = valid_q && ((row_q == 4'd0) || (score > max_q));

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    addr_d   = addr_q;
    index_d  = index_q;
    max_d    = max_q;
    answer_d = answer_q;
    row_d    = addr_q;
    valid_d  = rd_en;

    if (take) begin
      max_d   = score;
      index_d = row_q;
    end

    unique case (state_q)
      StFetch: begin
        addr_d = addr_q + 4'd1;
        if (addr_q == LastRow) begin
          state_d = StDrain;
          addr_d  = 4'd0;
        end
      end
      StDrain: begin
        state_d  = StDone;
        answer_d = index_d;
      end
      default: ;
    endcase

    if (accept) begin
      state_d = StFetch;
      data_d  = data_in;
      addr_d  = 4'd0;
      index_d = 4'd0;
      max_d   = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      data_q   <= '0;
      addr_q   <= 4'd0;
      row_q    <= 4'd0;
      index_q  <= 4'd0;
      answer_q <= 4'd0;
      max_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
      row_q    <= row_d;
      index_q  <= index_d;
      answer_q <= answer_d;
      max_q    <= max_d;
      valid_q  <= valid_d;
    end
  end

  assign weight_rd_en = rd_en;
  assign weight_addr  = addr_q;
  assign busy         = (state_q == StFetch) || (state_q == StDrain);
  assign done         = (state_q == StDone);
  assign answer       = answer_q;
`ifdef FINAL_LAYER_SCORE_OUT_EN
  assign max_score    = max_q;
`endif

endmodule
